// File: rtl/mm_frame_pkg.sv
// Shared frame layout, magic bytes and builder state encoding for mm_frame_gen.
package mm_frame_pkg;

  localparam int FRAME_W     = 128;
  localparam int MAGIC_W     = 8;
  localparam int HDR_BASE_W  = 12;
  localparam int HDR_TS_W    = 44;
  localparam int HDR_CHAN_W  = 16;
  localparam int HDR_RSVD_W  = 48;
  localparam int FTR_CNT_W   = 16;
  localparam int FTR_SEQ_W   = 32;
  localparam int FTR_RSVD_W  = 71;

  localparam logic [MAGIC_W-1:0] HDR_MAGIC = 8'hAA;
  localparam logic [MAGIC_W-1:0] FTR_MAGIC = 8'h55;

  // Header: [127:120] magic, [119:108] baseline, [107:64] time stamp, [63:48] channel
  typedef struct packed {
    logic [MAGIC_W-1:0]    magic;
    logic [HDR_BASE_W-1:0] baseline;
    logic [HDR_TS_W-1:0]   time_stamp;
    logic [HDR_CHAN_W-1:0] channel;
    logic [HDR_RSVD_W-1:0] rsvd;
  } hdr_t;

  // Footer: [127:120] magic, [119:104] word count, [103:72] sequence, [71] truncated
  typedef struct packed {
    logic [MAGIC_W-1:0]    magic;
    logic [FTR_CNT_W-1:0]  word_cnt;
    logic [FTR_SEQ_W-1:0]  seq;
    logic                  trunc;
    logic [FTR_RSVD_W-1:0] rsvd;
  } ftr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_SKIP = 2'd2
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mm_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a write is accepted when full if a pop
// happens in the same cycle. rd_dat reads as zero while empty.
module mm_sync_fifo #(
  parameter int WIDTH      = 129,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_vld,
  input  logic [WIDTH-1:0]      wr_dat,
  output logic                  rd_vld,
  output logic [WIDTH-1:0]      rd_dat,
  input  logic                  rd_rdy,
  output logic [DEPTH_LOG2:0]   free_count
);

  localparam logic [DEPTH_LOG2:0]   DEPTH   = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem_q [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  empty, full, push, pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == DEPTH);
    pop      = rd_rdy && !empty;
    push     = wr_vld && (!full || pop);
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_dat;
  end

  assign rd_vld     = !empty;
  assign rd_dat     = empty ? '0 : mem_q[rd_ptr_q];
  assign free_count = DEPTH - count_q;

endmodule

// File: rtl/mm_frame_gen.sv
// Packs each triggered interval into header/data/footer AXI4-Stream frames; 2-cycle
// input-to-output latency when empty. Never stalls upstream: truncates or drops on lack of space.
module mm_frame_gen
  import mm_frame_pkg::*;
#(
  parameter int          TIME_STAMP_WIDTH     = 44,
  parameter int          ADC_RESOLUTION_WIDTH = 12,
  parameter int          TDATA_WIDTH          = 128,
  parameter logic [15:0] CHANNEL_ID           = 16'd0,
  parameter int          MAX_DATA_WORDS       = 256,
  parameter int          FIFO_DEPTH_LOG2      = 9
) (
  input  logic                            AXIS_ACLK,
  input  logic                            AXIS_ARESETN,
  input  logic                            TRIGGERED,
  input  logic [TDATA_WIDTH-1:0]          DATA,
  input  logic                            VALID,
  input  logic [TIME_STAMP_WIDTH-1:0]     TIME_STAMP,
  input  logic [ADC_RESOLUTION_WIDTH-1:0] BASELINE_WHEN_HIT,
  output logic [TDATA_WIDTH-1:0]          M_AXIS_TDATA,
  output logic                            M_AXIS_TVALID,
  output logic                            M_AXIS_TLAST,
  input  logic                            M_AXIS_TREADY,
  output logic [15:0]                     DROP_COUNT
);

  localparam int              CW        = FIFO_DEPTH_LOG2 + 1;
  localparam logic [15:0]     MAX_WORDS = 16'(MAX_DATA_WORDS);
  localparam logic [CW-1:0]   HDR_NEED  = CW'(3);
  localparam logic [CW-1:0]   DATA_NEED = CW'(2);

  logic rst_meta_q, rst_sync_q;

  // Assert immediately, release on a clock edge
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  state_e                 state_q, state_d;
  logic                   trig_q, valid_d1_q;
  logic [TDATA_WIDTH-1:0] data_d1_q;
  logic [15:0]            word_cnt_q, word_cnt_d;
  logic                   trunc_q, trunc_d;
  logic [31:0]            seq_q, seq_d;
  logic [15:0]            drop_cnt_q, drop_cnt_d;

  logic                   rise;
  logic                   wr_vld;
  logic [TDATA_WIDTH:0]   wr_dat;
  logic [TDATA_WIDTH:0]   rd_dat;
  logic [CW-1:0]          free_count;
  hdr_t                   hdr;
  ftr_t                   ftr;

  assign hdr = '{magic:      HDR_MAGIC,
                 baseline:   HDR_BASE_W'(BASELINE_WHEN_HIT),
                 time_stamp: HDR_TS_W'(TIME_STAMP),
                 channel:    CHANNEL_ID,
                 rsvd:       '0};

  assign ftr = '{magic:    FTR_MAGIC,
                 word_cnt: word_cnt_q,
                 seq:      seq_q,
                 trunc:    trunc_q,
                 rsvd:     '0};

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    trunc_d    = trunc_q;
    seq_d      = seq_q;
    drop_cnt_d = drop_cnt_q;
    wr_vld     = 1'b0;
    wr_dat     = '0;
    rise       = TRIGGERED && !trig_q;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          if (free_count >= HDR_NEED) begin
            wr_vld     = 1'b1;
            wr_dat     = {1'b0, TDATA_WIDTH'(hdr)};
            word_cnt_d = '0;
            trunc_d    = 1'b0;
            state_d    = ST_DATA;
          end else begin
            drop_cnt_d = sat_inc16(drop_cnt_q);
            state_d    = ST_SKIP;
          end
        end
      end
      ST_DATA: begin
        if (trig_q) begin
          // The last free slot always stays reserved for the footer
          if (valid_d1_q) begin
            if ((word_cnt_q < MAX_WORDS) && (free_count >= DATA_NEED)) begin
              wr_vld     = 1'b1;
              wr_dat     = {1'b0, data_d1_q};
              word_cnt_d = word_cnt_q + 16'd1;
            end else begin
              trunc_d = 1'b1;
            end
          end
        end else begin
          wr_vld = 1'b1;
          wr_dat = {1'b1, TDATA_WIDTH'(ftr)};
          seq_d  = seq_q + 32'd1;
          if (rise) begin
            drop_cnt_d = sat_inc16(drop_cnt_q);
            state_d    = ST_SKIP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_SKIP: begin
        if (!TRIGGERED) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge AXIS_ACLK or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q    <= ST_IDLE;
      trig_q     <= 1'b0;
      valid_d1_q <= 1'b0;
      data_d1_q  <= '0;
      word_cnt_q <= '0;
      trunc_q    <= 1'b0;
      seq_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      trig_q     <= TRIGGERED;
      valid_d1_q <= VALID;
      data_d1_q  <= DATA;
      word_cnt_q <= word_cnt_d;
      trunc_q    <= trunc_d;
      seq_q      <= seq_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  mm_sync_fifo #(
    .WIDTH      (TDATA_WIDTH + 1),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk        (AXIS_ACLK),
    .rst_n      (rst_sync_q),
    .wr_vld     (wr_vld),
    .wr_dat     (wr_dat),
    .rd_vld     (M_AXIS_TVALID),
    .rd_dat     (rd_dat),
    .rd_rdy     (M_AXIS_TREADY),
    .free_count (free_count)
  );

  assign M_AXIS_TDATA = rd_dat[TDATA_WIDTH-1:0];
  assign M_AXIS_TLAST = rd_dat[TDATA_WIDTH];
  assign DROP_COUNT   = drop_cnt_q;

endmodule
